spec_fetch_unit: RTL and testbench

//  Next-generation fetch unit. Fetches one instr/cycle from instr mem, writes it to the instr queue and

---
 rtl/spec_fetch_unit_pkg.sv | 39 +++
 rtl/spec_fetch_unit_chk.sv | 25 ++
 rtl/spec_recovery_fifo.sv | 86 ++++++++
 rtl/spec_fetch_unit.sv | 226 ++++++++++++++++++++++
 tb/tb_spec_fetch_unit.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spec_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// spec_fetch_unit_pkg
//   Shared types, opcode constants and decode helpers for the speculative fetch
//   unit and its recovery FIFO.
//   Contents:
//     word32_t          32-bit instruction / address word
//     *_OPCODE          major opcodes recognised by the fetch stage
//     fetch_action_e    per-cycle fetch decision
//     br_imm_extract()  branch immediate forwarded to the predictor
//     jmp_offset()      byte offset of a local jump (sign-extended, x4)
// -----------------------------------------------------------------------------
package spec_fetch_unit_pkg;

   typedef logic [31:0] word32_t;

   localparam logic [6:0] JMP_OPCODE = 7'b1100111;
   localparam logic [6:0] BR_OPCODE  = 7'b1100011;
   localparam logic [6:0] LD_OPCODE  = 7'b0000011;
   localparam logic [6:0] ST_OPCODE  = 7'b0100011;

   typedef enum logic [2:0] {
      FETCH_IDLE   = 3'd0,   // reset: nothing moves
      FETCH_SEQ    = 3'd1,   // write instr, PC+4
      FETCH_BRANCH = 3'd2,   // issue branch, push recovery PC
      FETCH_JUMP   = 3'd3,   // resolved locally, not queued
      FETCH_STALL  = 3'd4,   // hold PC (queue full / spec limit / mem op)
      FETCH_FLUSH  = 3'd5    // mispredict recovery
   } fetch_action_e;

   function automatic logic [11:0] br_imm_extract(input word32_t instr);
      return {instr[31:27], instr[16:10]};
   endfunction

   // Jump field is instr[31:7] in words; convert to a sign-extended byte offset.
   function automatic word32_t jmp_offset(input word32_t instr);
      return {{5{instr[31]}}, instr[31:7], 2'b00};
   endfunction

endpackage

// File: rtl/spec_fetch_unit_chk.sv
// -----------------------------------------------------------------------------
// spec_fetch_unit_chk
//   Protocol checker for the fetch unit: a branch resolution must never arrive
//   while no branch is outstanding (such an event is ignored by the datapath).
//   Ports:
//     clk_i, reset_i   clock, synchronous active-high reset
//     cond_eval_i      branch resolution strobe
//     spec_depth_i     outstanding branch count
// -----------------------------------------------------------------------------
module spec_fetch_unit_chk #(
   parameter int TAG_W = 2
)(
   input logic           clk_i,
   input logic           reset_i,
   input logic           cond_eval_i,
   input logic [TAG_W:0] spec_depth_i
);

   // Resolution with nothing outstanding is a protocol error upstream.
   a_no_eval_when_empty : assert property (
      @(posedge clk_i) disable iff (reset_i)
      !(cond_eval_i && (spec_depth_i == {(TAG_W+1){1'b0}}))
   );

endmodule

// File: rtl/spec_recovery_fifo.sv
// -----------------------------------------------------------------------------
// spec_recovery_fifo
//   In-order FIFO holding the not-predicted PC of every outstanding branch.
//   Pointers wrap modulo DEPTH (DEPTH need not be a power of two). A pop and a
//   push in the same cycle are legal even when full: the popped slot is the one
//   being written.
//   Ports:
//     clk_i, reset_i   clock, synchronous active-high reset
//     clear_i          discard all entries (mispredict)
//     push_i / pop_i   enqueue push_data_i / dequeue head
//     head_data_o      oldest entry
//     count_o          number of valid entries (registered)
//     wr_ptr_o         slot the next push will occupy
// -----------------------------------------------------------------------------
module spec_recovery_fifo #(
   parameter int  DEPTH = 4,
   parameter int  WIDTH = 32,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] push_data_i,
   output logic [WIDTH-1:0] head_data_o,
   output logic [PTR_W:0]   count_o,
   output logic [PTR_W-1:0] wr_ptr_o
);

   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W:0]   count_r;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      if (ptr == LAST_PTR) begin
         return {PTR_W{1'b0}};
      end else begin
         return ptr + PTR_W'(1);
      end
   endfunction

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rd_ptr_r <= {PTR_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {(PTR_W+1){1'b0}};
      end else if (clear_i) begin
         rd_ptr_r <= {PTR_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {(PTR_W+1){1'b0}};
      end else begin
         if (push_i) begin
            wr_ptr_r <= ptr_inc(wr_ptr_r);
         end
         if (pop_i) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({push_i, pop_i})
            2'b10:   count_r <= count_r + (PTR_W+1)'(1);
            2'b01:   count_r <= count_r - (PTR_W+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; cleared on reset so stale PCs never leak out.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else if (push_i && !clear_i) begin
         mem_r[wr_ptr_r] <= push_data_i;
      end
   end

   assign head_data_o = mem_r[rd_ptr_r];
   assign count_o     = count_r;
   assign wr_ptr_o    = wr_ptr_r;

endmodule

// File: rtl/spec_fetch_unit.sv
// -----------------------------------------------------------------------------
// spec_fetch_unit
//   Fetches one instruction per cycle, forwards it to the instruction queue,
//   resolves jumps locally and speculates past up to MAX_SPEC unresolved
//   branches. The not-predicted PC of every issued branch is kept in an
//   in-order recovery FIFO; a mispredict on the oldest branch redirects fetch
//   to that PC and flushes all speculative state.
//   Optional feature: define FETCH_PERF_CNT_EN to add saturating stall and
//   mispredict counters (stall_cnt_o, mispred_cnt_o).
//   Ports:
//     clk_i, reset_i              clock, synchronous active-high reset
//     instr_i / program_counter_o instruction at the fetch PC / fetch PC
//     program_counter_branched_i  predictor target, br_taken_i prediction
//     br_imm_o                    immediate sent to the predictor
//     issuing_branch_o, br_tag_o  branch issued this cycle and its FIFO slot
//     cond_eval_i, corr_pred_i    oldest branch resolved / prediction correct
//     iq_full_i, iq_write_o       queue back-pressure / queue write strobe
//     fetched_instr_o             instruction written to the queue
//     flush_o                     mispredict flush strobe
//     spec_depth_o                outstanding branch count (registered)
// -----------------------------------------------------------------------------
module spec_fetch_unit
   import spec_fetch_unit_pkg::*;
#(
   parameter int      IMM_WIDTH = 12,
   parameter int      MAX_SPEC  = 4,
   parameter word32_t RESET_PC  = 32'h0000_0000,
   localparam int     TAG_W     = (MAX_SPEC > 1) ? $clog2(MAX_SPEC) : 1
)(
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic [31:0]          instr_i,
   output logic [31:0]          program_counter_o,
   input  logic [31:0]          program_counter_branched_i,
   input  logic                 br_taken_i,
   output logic [IMM_WIDTH-1:0] br_imm_o,
   output logic                 issuing_branch_o,
   output logic [TAG_W-1:0]     br_tag_o,
   input  logic                 cond_eval_i,
   input  logic                 corr_pred_i,
   input  logic                 iq_full_i,
   output logic                 iq_write_o,
   output logic [31:0]          fetched_instr_o,
   output logic                 flush_o,
   output logic [TAG_W:0]       spec_depth_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]          stall_cnt_o,
   output logic [15:0]          mispred_cnt_o
`endif
);

   localparam logic [TAG_W:0] MAX_SPEC_C = (TAG_W+1)'(MAX_SPEC);
   localparam logic [TAG_W:0] DEPTH_ZERO = {(TAG_W+1){1'b0}};

   word32_t       pc_r;
   word32_t       pc_next_s;
   word32_t       pc_plus4_s;
   word32_t       head_s;
   word32_t       push_data_s;
   logic [6:0]    opcode_s;
   logic [TAG_W:0]   count_s;
   logic [TAG_W:0]   count_after_pop_s;
   logic [TAG_W-1:0] wr_ptr_s;
   logic          eval_valid_s;
   logic          mispredict_s;
   logic          pop_s;
   logic          push_s;
   logic          clear_s;
   logic          iq_write_s;
   logic          issue_s;
   logic          flush_s;
   logic          stall_s;
   fetch_action_e action_s;

   assign opcode_s     = instr_i[6:0];
   assign pc_plus4_s   = pc_r + 32'd4;
   // A resolution with nothing outstanding is ignored.
   assign eval_valid_s = cond_eval_i & (count_s != DEPTH_ZERO) & ~reset_i;
   assign mispredict_s = eval_valid_s & ~corr_pred_i;
   assign pop_s        = eval_valid_s & corr_pred_i;
   // The slot freed by a same-cycle correct resolution is usable for a new branch.
   assign count_after_pop_s = count_s - {{TAG_W{1'b0}}, pop_s};

   // Per-cycle fetch decision in priority order.
   always_comb begin
      action_s = FETCH_IDLE;
      if (reset_i) begin
         action_s = FETCH_IDLE;
      end else if (mispredict_s) begin
         action_s = FETCH_FLUSH;
      end else if (iq_full_i) begin
         action_s = FETCH_STALL;
      end else begin
         case (opcode_s)
            BR_OPCODE: begin
               if (count_after_pop_s < MAX_SPEC_C) begin
                  action_s = FETCH_BRANCH;
               end else begin
                  action_s = FETCH_STALL;
               end
            end
            LD_OPCODE, ST_OPCODE: begin
               // No memory operations under speculation.
               if (count_after_pop_s != DEPTH_ZERO) begin
                  action_s = FETCH_STALL;
               end else begin
                  action_s = FETCH_SEQ;
               end
            end
            JMP_OPCODE: action_s = FETCH_JUMP;
            default:    action_s = FETCH_SEQ;
         endcase
      end
   end

   // Strobes, next PC and recovery push derived from the decision.
   always_comb begin
      pc_next_s   = pc_r;
      push_data_s = pc_plus4_s;
      iq_write_s  = 1'b0;
      issue_s     = 1'b0;
      flush_s     = 1'b0;
      push_s      = 1'b0;
      clear_s     = 1'b0;
      stall_s     = 1'b0;
      case (action_s)
         FETCH_FLUSH: begin
            flush_s   = 1'b1;
            clear_s   = 1'b1;
            pc_next_s = head_s;
         end
         FETCH_BRANCH: begin
            issue_s    = 1'b1;
            push_s     = 1'b1;
            iq_write_s = 1'b1;
            if (br_taken_i) begin
               pc_next_s   = program_counter_branched_i;
               push_data_s = pc_plus4_s;
            end else begin
               pc_next_s   = pc_plus4_s;
               push_data_s = program_counter_branched_i;
            end
         end
         FETCH_JUMP: begin
            pc_next_s = pc_r + jmp_offset(instr_i);
         end
         FETCH_SEQ: begin
            iq_write_s = 1'b1;
            pc_next_s  = pc_plus4_s;
         end
         FETCH_STALL: begin
            stall_s = 1'b1;
         end
         default: begin
            pc_next_s = pc_r;
         end
      endcase
   end

   // Fetch PC register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         pc_r <= RESET_PC;
      end else begin
         pc_r <= pc_next_s;
      end
   end

   spec_recovery_fifo #(
      .DEPTH (MAX_SPEC),
      .WIDTH (32)
   ) u_recovery_fifo (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .clear_i     (clear_s),
      .push_i      (push_s),
      .pop_i       (pop_s),
      .push_data_i (push_data_s),
      .head_data_o (head_s),
      .count_o     (count_s),
      .wr_ptr_o    (wr_ptr_s)
   );

   spec_fetch_unit_chk #(
      .TAG_W (TAG_W)
   ) u_chk (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .cond_eval_i  (cond_eval_i),
      .spec_depth_i (count_s)
   );

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt_r;
   logic [15:0] mispred_cnt_r;

   // Saturating performance counters.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         stall_cnt_r   <= 32'd0;
         mispred_cnt_r <= 16'd0;
      end else begin
         if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
         end
         if (flush_s && (mispred_cnt_r != 16'hFFFF)) begin
            mispred_cnt_r <= mispred_cnt_r + 16'd1;
         end
      end
   end

   assign stall_cnt_o   = stall_cnt_r;
   assign mispred_cnt_o = mispred_cnt_r;
`endif

   assign program_counter_o = pc_r;
   assign br_imm_o          = IMM_WIDTH'(br_imm_extract(instr_i));
   assign issuing_branch_o  = issue_s;
   assign br_tag_o          = wr_ptr_s;
   assign iq_write_o        = iq_write_s;
   assign fetched_instr_o   = instr_i;
   assign flush_o           = flush_s;
   assign spec_depth_o      = count_s;

endmodule

// File: tb/tb_spec_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_spec_fetch_unit
//   Directed scenarios plus a randomized run checked against a queue-based
//   reference model of the fetch rules. MAX_SPEC=3 so FIFO pointers wrap at a
//   non-power-of-two depth; RESET_PC=0x100.
// -----------------------------------------------------------------------------
module tb_spec_fetch_unit;

   localparam int          MS  = 3;
   localparam int          TW  = 2;
   localparam logic [31:0] RPC = 32'h0000_0100;

   localparam logic [6:0] OP_JMP = 7'b1100111;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_ST  = 7'b0100011;
   localparam logic [6:0] OP_ALU = 7'b0110011;

   localparam logic [31:0] I_ALU = 32'h0000_0033;
   localparam logic [31:0] I_BR  = 32'h0000_0063;
   localparam logic [31:0] I_BRX = 32'hF800_FC63;
   localparam logic [31:0] I_LD  = 32'h0000_2003;

   logic          clk_i = 1'b0;
   logic          reset_i;
   logic [31:0]   instr_i;
   logic [31:0]   program_counter_o;
   logic [31:0]   program_counter_branched_i;
   logic          br_taken_i;
   logic [11:0]   br_imm_o;
   logic          issuing_branch_o;
   logic [TW-1:0] br_tag_o;
   logic          cond_eval_i;
   logic          corr_pred_i;
   logic          iq_full_i;
   logic          iq_write_o;
   logic [31:0]   fetched_instr_o;
   logic          flush_o;
   logic [TW:0]   spec_depth_o;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0]   stall_cnt_o;
   logic [15:0]   mispred_cnt_o;
`endif

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [31:0] m_pc;
   logic [31:0] m_q[$];
   int          m_wr;
   logic        e_iqw, e_issue, e_flush, e_push, e_pop, e_clear;
   int          e_tag;
   logic [31:0] e_next, e_pushv;

   always #5 clk_i = ~clk_i;

   spec_fetch_unit #(
      .IMM_WIDTH (12),
      .MAX_SPEC  (MS),
      .RESET_PC  (RPC)
   ) dut (
      .clk_i                      (clk_i),
      .reset_i                    (reset_i),
      .instr_i                    (instr_i),
      .program_counter_o          (program_counter_o),
      .program_counter_branched_i (program_counter_branched_i),
      .br_taken_i                 (br_taken_i),
      .br_imm_o                   (br_imm_o),
      .issuing_branch_o           (issuing_branch_o),
      .br_tag_o                   (br_tag_o),
      .cond_eval_i                (cond_eval_i),
      .corr_pred_i                (corr_pred_i),
      .iq_full_i                  (iq_full_i),
      .iq_write_o                 (iq_write_o),
      .fetched_instr_o            (fetched_instr_o),
      .flush_o                    (flush_o),
      .spec_depth_o               (spec_depth_o)
`ifdef FETCH_PERF_CNT_EN
      ,
      .stall_cnt_o                (stall_cnt_o),
      .mispred_cnt_o              (mispred_cnt_o)
`endif
   );

   function automatic logic [31:0] mk_jmp(input int words);
      logic [24:0] f;
      f = 25'(words);
      return {f, OP_JMP};
   endfunction

   // Drive inputs just after a falling edge and let combinational outputs settle.
   task automatic drive(input logic [31:0] ins, input logic [31:0] tg, input logic tk,
                        input logic ce, input logic cp, input logic fl);
      instr_i = ins; program_counter_branched_i = tg; br_taken_i = tk;
      cond_eval_i = ce; corr_pred_i = cp; iq_full_i = fl;
      #1;
   endtask

   task automatic tick();
      @(negedge clk_i);
   endtask

   // Expected behaviour for the current inputs, from the fetch rules.
   function automatic void model_eval();
      int  n;
      int  off;
      logic signed [24:0] jf;
      bit  cev;
      e_iqw = 1'b0; e_issue = 1'b0; e_flush = 1'b0; e_push = 1'b0; e_pop = 1'b0;
      e_clear = 1'b0; e_tag = m_wr; e_next = m_pc; e_pushv = 32'd0;
      if (reset_i) begin
         e_next = RPC; e_clear = 1'b1;
         return;
      end
      cev = cond_eval_i && (m_q.size() > 0);
      if (cev && !corr_pred_i) begin
         e_flush = 1'b1; e_clear = 1'b1; e_next = m_q[0];
         return;
      end
      e_pop = cev;
      n = m_q.size() - (cev ? 1 : 0);
      if (iq_full_i) return;
      case (instr_i[6:0])
         OP_BR: begin
            if (n < MS) begin
               e_issue = 1'b1; e_iqw = 1'b1; e_push = 1'b1;
               e_pushv = br_taken_i ? m_pc + 32'd4 : program_counter_branched_i;
               e_next  = br_taken_i ? program_counter_branched_i : m_pc + 32'd4;
            end
         end
         OP_LD, OP_ST: begin
            if (n == 0) begin
               e_iqw = 1'b1; e_next = m_pc + 32'd4;
            end
         end
         OP_JMP: begin
            jf = instr_i[31:7];
            off = jf;
            e_next = m_pc + 32'(off * 4);
         end
         default: begin
            e_iqw = 1'b1; e_next = m_pc + 32'd4;
         end
      endcase
   endfunction

   task automatic model_commit();
      m_pc = e_next;
      if (e_clear) begin
         m_q.delete();
         m_wr = 0;
      end else begin
         if (e_pop) void'(m_q.pop_front());
         if (e_push) begin
            m_q.push_back(e_pushv);
            m_wr = (m_wr + 1) % MS;
         end
      end
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      drive(I_ALU, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); tick();
      drive(I_ALU, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (program_counter_o !== RPC) begin errors++; $display("FAIL reset_pc got %h exp %h", program_counter_o, RPC); end
      checks++; if (spec_depth_o !== 3'd0) begin errors++; $display("FAIL reset_depth got %0d exp 0", spec_depth_o); end
      checks++; if ({iq_write_o, issuing_branch_o, flush_o} !== 3'b000) begin errors++; $display("FAIL reset_strobes got %b exp 000", {iq_write_o, issuing_branch_o, flush_o}); end
      reset_i = 1'b0;
      drive(I_ALU, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++; if (iq_write_o !== 1'b0) begin errors++; $display("FAIL full_no_write got %b exp 0", iq_write_o); end
      tick();
      checks++; if (program_counter_o !== RPC) begin errors++; $display("FAIL full_hold_pc got %h exp %h", program_counter_o, RPC); end
   endtask

   task automatic test_alu();
      drive(mk_jmp(-64), 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (iq_write_o !== 1'b0) begin errors++; $display("FAIL jmp_no_write got %b exp 0", iq_write_o); end
      tick();
      checks++; if (program_counter_o !== 32'h0) begin errors++; $display("FAIL jmp_back_pc got %h exp 00000000", program_counter_o); end
      for (int i = 1; i <= 4; i++) begin
         drive(I_ALU, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
         checks++; if (iq_write_o !== 1'b1) begin errors++; $display("FAIL alu_write[%0d] got %b exp 1", i, iq_write_o); end
         checks++; if (fetched_instr_o !== I_ALU) begin errors++; $display("FAIL alu_instr[%0d] got %h exp %h", i, fetched_instr_o, I_ALU); end
         tick();
         checks++; if (program_counter_o !== 32'(4 * i)) begin errors++; $display("FAIL alu_pc[%0d] got %h exp %h", i, program_counter_o, 32'(4 * i)); end
      end
   endtask

   task automatic test_branch();
      drive(I_BRX, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (issuing_branch_o !== 1'b1 || iq_write_o !== 1'b1) begin errors++; $display("FAIL br0_issue got %b%b exp 11", issuing_branch_o, iq_write_o); end
      checks++; if (br_tag_o !== 2'd0) begin errors++; $display("FAIL br0_tag got %0d exp 0", br_tag_o); end
      checks++; if (br_imm_o !== 12'hFBF) begin errors++; $display("FAIL br_imm got %h exp fbf", br_imm_o); end
      tick();
      checks++; if (program_counter_o !== 32'h40 || spec_depth_o !== 3'd1) begin errors++; $display("FAIL br0_state got pc %h d %0d exp pc 40 d 1", program_counter_o, spec_depth_o); end
      drive(I_BR, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (br_tag_o !== 2'd1 || issuing_branch_o !== 1'b1) begin errors++; $display("FAIL br1_tag got %0d/%b exp 1/1", br_tag_o, issuing_branch_o); end
      tick();
      checks++; if (program_counter_o !== 32'h44 || spec_depth_o !== 3'd2) begin errors++; $display("FAIL br1_state got pc %h d %0d exp pc 44 d 2", program_counter_o, spec_depth_o); end
   endtask

   task automatic test_mispredict();
      drive(I_ALU, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++; if ({flush_o, iq_write_o, issuing_branch_o} !== 3'b100) begin errors++; $display("FAIL mispred_strobes got %b exp 100", {flush_o, iq_write_o, issuing_branch_o}); end
      tick();
      checks++; if (program_counter_o !== 32'h14 || spec_depth_o !== 3'd0) begin errors++; $display("FAIL mispred_state got pc %h d %0d exp pc 14 d 0", program_counter_o, spec_depth_o); end
      drive(I_ALU, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (flush_o !== 1'b0 || iq_write_o !== 1'b1) begin errors++; $display("FAIL post_flush got %b%b exp 01", flush_o, iq_write_o); end
      tick();
      checks++; if (program_counter_o !== 32'h18) begin errors++; $display("FAIL post_flush_pc got %h exp 18", program_counter_o); end
   endtask

   task automatic test_spec_limit();
      for (int i = 0; i < MS; i++) begin
         drive(I_BR, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0);
         checks++; if (issuing_branch_o !== 1'b1 || br_tag_o !== TW'(i)) begin errors++; $display("FAIL fill_tag[%0d] got %b/%0d exp 1/%0d", i, issuing_branch_o, br_tag_o, i); end
         tick();
      end
      checks++; if (program_counter_o !== 32'h24 || spec_depth_o !== 3'd3) begin errors++; $display("FAIL fill_state got pc %h d %0d exp pc 24 d 3", program_counter_o, spec_depth_o); end
      drive(I_BR, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (issuing_branch_o !== 1'b0 || iq_write_o !== 1'b0) begin errors++; $display("FAIL limit_block got %b%b exp 00", issuing_branch_o, iq_write_o); end
      tick();
      checks++; if (program_counter_o !== 32'h24) begin errors++; $display("FAIL limit_hold got %h exp 24", program_counter_o); end
      drive(I_BR, 32'h200, 1'b0, 1'b1, 1'b1, 1'b0);
      checks++; if (issuing_branch_o !== 1'b1 || br_tag_o !== 2'd0) begin errors++; $display("FAIL pop_push_issue got %b/%0d exp 1/0", issuing_branch_o, br_tag_o); end
      tick();
      checks++; if (program_counter_o !== 32'h28 || spec_depth_o !== 3'd3) begin errors++; $display("FAIL pop_push_state got pc %h d %0d exp pc 28 d 3", program_counter_o, spec_depth_o); end
      for (int i = 0; i < MS; i++) begin
         drive(I_ALU, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1);
         tick();
      end
      checks++; if (program_counter_o !== 32'h28 || spec_depth_o !== 3'd0) begin errors++; $display("FAIL drain_state got pc %h d %0d exp pc 28 d 0", program_counter_o, spec_depth_o); end
   endtask

   task automatic test_jump_ld();
      drive(mk_jmp(-2), 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(mk_jmp(-1), 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (iq_write_o !== 1'b0) begin errors++; $display("FAIL jmm1_write got %b exp 0", iq_write_o); end
      tick();
      checks++; if (program_counter_o !== 32'h1C) begin errors++; $display("FAIL jmm1_pc got %h exp 1c", program_counter_o); end
      drive(I_BR, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (br_tag_o !== 2'd1) begin errors++; $display("FAIL wrap_tag got %0d exp 1", br_tag_o); end
      tick();
      for (int i = 0; i < 2; i++) begin
         drive(I_LD, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
         checks++; if (iq_write_o !== 1'b0) begin errors++; $display("FAIL ld_spec_write[%0d] got %b exp 0", i, iq_write_o); end
         tick();
         checks++; if (program_counter_o !== 32'h20) begin errors++; $display("FAIL ld_hold[%0d] got %h exp 20", i, program_counter_o); end
      end
      drive(I_LD, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      checks++; if (iq_write_o !== 1'b1) begin errors++; $display("FAIL ld_release got %b exp 1", iq_write_o); end
      tick();
      checks++; if (program_counter_o !== 32'h24 || spec_depth_o !== 3'd0) begin errors++; $display("FAIL ld_release_state got pc %h d %0d exp pc 24 d 0", program_counter_o, spec_depth_o); end
   endtask

   task automatic test_random();
      logic [31:0] ins;
      logic [11:0] eimm;
      reset_i = 1'b1;
      drive(I_ALU, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      reset_i = 1'b0;
      m_pc = RPC; m_q.delete(); m_wr = 0;
      for (int c = 0; c < 3000; c++) begin
         ins = $urandom();
         case ($urandom_range(0, 9))
            0, 1, 2: ins[6:0] = OP_BR;
            3:       ins[6:0] = OP_LD;
            4:       ins[6:0] = OP_ST;
            5:       ins[6:0] = OP_JMP;
            6, 7, 8: ins[6:0] = OP_ALU;
            default: ins[6:0] = ins[6:0];
         endcase
         reset_i = ($urandom_range(0, 99) < 2);
         drive(ins, $urandom() & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
               (m_q.size() > 0) && ($urandom_range(0, 99) < 35),
               ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 15));
         model_eval();
         eimm = {ins[31:27], ins[16:10]};
         checks++; if (program_counter_o !== m_pc) begin errors++; $display("FAIL rnd_pc cyc %0d got %h exp %h", c, program_counter_o, m_pc); end
         checks++; if (spec_depth_o !== (TW+1)'(m_q.size())) begin errors++; $display("FAIL rnd_depth cyc %0d got %0d exp %0d", c, spec_depth_o, m_q.size()); end
         checks++; if (iq_write_o !== e_iqw) begin errors++; $display("FAIL rnd_iq_write cyc %0d got %b exp %b", c, iq_write_o, e_iqw); end
         checks++; if (issuing_branch_o !== e_issue) begin errors++; $display("FAIL rnd_issue cyc %0d got %b exp %b", c, issuing_branch_o, e_issue); end
         checks++; if (flush_o !== e_flush) begin errors++; $display("FAIL rnd_flush cyc %0d got %b exp %b", c, flush_o, e_flush); end
         checks++; if (br_imm_o !== eimm || fetched_instr_o !== ins) begin errors++; $display("FAIL rnd_fwd cyc %0d got %h/%h exp %h/%h", c, br_imm_o, fetched_instr_o, eimm, ins); end
         if (e_issue) begin
            checks++; if (br_tag_o !== TW'(e_tag)) begin errors++; $display("FAIL rnd_tag cyc %0d got %0d exp %0d", c, br_tag_o, e_tag); end
         end
         tick();
         model_commit();
      end
      reset_i = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_alu();
      test_branch();
      test_mispredict();
      test_spec_limit();
      test_jump_ld();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
